// File: rtl/axi_lite_rd_arbiter.sv
// axi_lite_rd_arbiter
// N-to-1 AXI-Lite read-channel arbiter placed in front of one slave port.
// One master owns the slave from grant until its R handshake completes.
// Round-robin priority advances only when a read finishes, so a master
// that wins the grant keeps its turn until its data has been returned.
module axi_lite_rd_arbiter #(
    parameter int N          = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int GID_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N-1:0]            s_arvalid,
    input  logic [N*ADDR_WIDTH-1:0] s_araddr,
    output logic [N-1:0]            s_arready,
    output logic [N-1:0]            s_rvalid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    input  logic [N-1:0]            s_rready,
    output logic                    m_arvalid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    input  logic                    m_arready,
    input  logic                    m_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    output logic                    m_rready,
    output logic [GID_W-1:0]        grant_id,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    logic [GID_W-1:0] last_id;
    logic [GID_W-1:0] pick;
    int               best_dist;

    // Round-robin pick: the requester closest after last_id (wrapping) wins.
    always_comb begin
        pick      = '0;
        best_dist = N;
        for (int j = 0; j < N; j++) begin
            if (s_arvalid[j] && (((j + N - int'(last_id) - 1) % N) < best_dist)) begin
                best_dist = (j + N - int'(last_id) - 1) % N;
                pick      = GID_W'(j);
            end
        end
    end

    // Control FSM: grant in IDLE, forward AR in ADDR, forward R in DATA.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant_id <= '0;
            last_id  <= GID_W'(N - 1);
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_arvalid) begin
                        grant_id <= pick;
                        state    <= ADDR;
                        busy     <= 1'b1;
                    end
                end
                ADDR: begin
                    if (m_arvalid && m_arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (m_rvalid && m_rready) begin
                        last_id <= grant_id;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Handshake routing: only the granted master is connected, only in its phase.
    always_comb begin
        m_arvalid = 1'b0;
        m_araddr  = '0;
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == GID_W'(i)) begin
                if (state == ADDR) begin
                    m_arvalid    = s_arvalid[i];
                    m_araddr     = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    s_arready[i] = m_arready;
                end
                if (state == DATA) begin
                    s_rvalid[i] = m_rvalid;
                    m_rready    = s_rready[i];
                end
            end
        end
    end

    // Read data and response are broadcast; only the granted master sees rvalid.
    always_comb begin
        s_rdata = m_rdata;
        s_rresp = m_rresp;
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Testbench for axi_lite_rd_arbiter: an N=4 instance for routing, fairness,
// backpressure, reset and randomized traffic, plus an N=1 instance.
module tb_axi_lite_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    // N = 4 instance signals
    logic [3:0]      arv4, ardy4_s, rv4_s, rrdy4;
    logic [4*AW-1:0] araddr4;
    logic            m_arv4, m_ardy4, m_rv4, m_rrdy4, busy4;
    logic [AW-1:0]   m_araddr4;
    logic [DW-1:0]   m_rdata4, s_rdata4;
    logic [1:0]      m_rresp4, s_rresp4, gid4;

    // N = 1 instance signals
    logic            arv1, ardy1_s, rv1_s, rrdy1;
    logic [AW-1:0]   araddr1, m_araddr1;
    logic            m_arv1, m_ardy1, m_rv1, m_rrdy1, busy1;
    logic [DW-1:0]   m_rdata1, s_rdata1;
    logic [1:0]      m_rresp1, s_rresp1;
    logic [0:0]      gid1;

    axi_lite_rd_arbiter #(.N(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u4 (
        .aclk(clk), .aresetn(rstn),
        .s_arvalid(arv4), .s_araddr(araddr4), .s_arready(ardy4_s),
        .s_rvalid(rv4_s), .s_rdata(s_rdata4), .s_rresp(s_rresp4), .s_rready(rrdy4),
        .m_arvalid(m_arv4), .m_araddr(m_araddr4), .m_arready(m_ardy4),
        .m_rvalid(m_rv4), .m_rdata(m_rdata4), .m_rresp(m_rresp4), .m_rready(m_rrdy4),
        .grant_id(gid4), .busy(busy4)
    );

    axi_lite_rd_arbiter #(.N(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u1 (
        .aclk(clk), .aresetn(rstn),
        .s_arvalid(arv1), .s_araddr(araddr1), .s_arready(ardy1_s),
        .s_rvalid(rv1_s), .s_rdata(s_rdata1), .s_rresp(s_rresp1), .s_rready(rrdy1),
        .m_arvalid(m_arv1), .m_araddr(m_araddr1), .m_arready(m_ardy1),
        .m_rvalid(m_rv1), .m_rdata(m_rdata1), .m_rresp(m_rresp1), .m_rready(m_rrdy1),
        .grant_id(gid1), .busy(busy1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  arv;
        logic        ardy;
        logic        rv;
        logic [3:0]  rrdy;
        logic        e_arv;
        logic [31:0] e_addr;
        logic [3:0]  e_ardy;
        logic [3:0]  e_rv;
        logic        e_rrdy;
        logic        e_busy;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t tbl[17];

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_1100;
    localparam logic [31:0] A2 = 32'h0000_2010;
    localparam logic [31:0] A3 = 32'h0000_3300;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arv4 = '0; m_ardy4 = 1'b0; m_rv4 = 1'b0; rrdy4 = '0;
        arv1 = 1'b0; m_ardy1 = 1'b0; m_rv1 = 1'b0; rrdy1 = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] arv, input logic ardy, input logic rv,
                                input logic [3:0] rrdy, input logic e_arv,
                                input logic [31:0] e_addr, input logic [3:0] e_ardy,
                                input logic [3:0] e_rv, input logic e_rrdy,
                                input logic e_busy, input logic [1:0] e_gid);
        vec_t v;
        v.arv = arv; v.ardy = ardy; v.rv = rv; v.rrdy = rrdy;
        v.e_arv = e_arv; v.e_addr = e_addr; v.e_ardy = e_ardy; v.e_rv = e_rv;
        v.e_rrdy = e_rrdy; v.e_busy = e_busy; v.e_gid = e_gid;
        return v;
    endfunction

    // randomized-test state
    int          owner;
    bit          in_data;
    int          last;
    bit          mreq[4];
    bit          mwait[4];
    logic [31:0] maddr[4];
    int          got[6];
    int          ng;

    initial begin
        // single read by master 2, then 3 -> 0 -> 1 rotation with backpressure
        tbl[0]  = mk(4'b0100, 0, 0, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(4'b0100, 0, 0, 4'b0000, 1, A2, 4'b0000, 4'b0000, 0, 1, 2);
        tbl[2]  = mk(4'b0100, 0, 0, 4'b0000, 1, A2, 4'b0000, 4'b0000, 0, 1, 2);
        tbl[3]  = mk(4'b0100, 1, 0, 4'b0000, 1, A2, 4'b0100, 4'b0000, 0, 1, 2);
        tbl[4]  = mk(4'b0000, 0, 0, 4'b0100, 0, 0,  4'b0000, 4'b0000, 1, 1, 2);
        tbl[5]  = mk(4'b0000, 0, 1, 4'b0100, 0, 0,  4'b0000, 4'b0100, 1, 1, 2);
        tbl[6]  = mk(4'b1011, 0, 0, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0, 0, 0);
        tbl[7]  = mk(4'b1011, 1, 0, 4'b0000, 1, A3, 4'b1000, 4'b0000, 0, 1, 3);
        tbl[8]  = mk(4'b0011, 0, 1, 4'b1111, 0, 0,  4'b0000, 4'b1000, 1, 1, 3);
        tbl[9]  = mk(4'b0011, 0, 0, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0, 0, 0);
        tbl[10] = mk(4'b0011, 1, 0, 4'b0000, 1, A0, 4'b0001, 4'b0000, 0, 1, 0);
        tbl[11] = mk(4'b0010, 0, 1, 4'b0001, 0, 0,  4'b0000, 4'b0001, 1, 1, 0);
        tbl[12] = mk(4'b0010, 0, 0, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0, 0, 0);
        tbl[13] = mk(4'b0010, 1, 0, 4'b0000, 1, A1, 4'b0010, 4'b0000, 0, 1, 1);
        tbl[14] = mk(4'b0000, 0, 1, 4'b0000, 0, 0,  4'b0000, 4'b0010, 0, 1, 1);
        tbl[15] = mk(4'b0000, 0, 1, 4'b0010, 0, 0,  4'b0000, 4'b0010, 1, 1, 1);
        tbl[16] = mk(4'b0000, 0, 0, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0, 0, 0);

        araddr4  = {A3, A2, A1, A0};
        araddr1  = 32'h0000_0ABC;
        m_rdata4 = 32'hDEAD_BEEF; m_rresp4 = 2'b00;
        m_rdata1 = 32'h1234_5678; m_rresp1 = 2'b01;
        idle_inputs();

        // reset values with every master requesting
        rstn = 1'b0;
        arv4 = 4'b1111;
        m_rdata4 = 32'hA5A5_0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("rst_out[%0d]", c),
                {m_arv4, ardy4_s, rv4_s, m_rrdy4, busy4, gid4, m_araddr4}, '0);
        end
        chk("rst_rdata_fwd", {s_rdata4, s_rresp4}, {32'hA5A5_0001, 2'b00});
        tick();
        rstn = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_release_grant", {m_arv4, busy4, gid4, m_araddr4}, {1'b1, 1'b1, 2'd0, A0});
        m_rdata4 = 32'hDEAD_BEEF;

        // table-driven routing and rotation
        do_reset();
        for (int i = 0; i < 17; i++) begin
            arv4 = tbl[i].arv; m_ardy4 = tbl[i].ardy; m_rv4 = tbl[i].rv; rrdy4 = tbl[i].rrdy;
            @(negedge clk);
            chk($sformatf("tbl[%0d]", i),
                {m_arv4, m_araddr4, ardy4_s, rv4_s, m_rrdy4, busy4},
                {tbl[i].e_arv, tbl[i].e_addr, tbl[i].e_ardy, tbl[i].e_rv, tbl[i].e_rrdy, tbl[i].e_busy});
            if (tbl[i].e_busy)
                chk($sformatf("tbl_gid[%0d]", i), 64'(gid4), 64'(tbl[i].e_gid));
            chk($sformatf("tbl_rdata[%0d]", i), {s_rdata4, s_rresp4}, {32'hDEAD_BEEF, 2'b00});
            tick();
        end

        // round-robin fairness: masters 0, 1, 3 request continuously
        do_reset();
        arv4 = 4'b1011; m_ardy4 = 1'b1; m_rv4 = 1'b1; rrdy4 = 4'b1111;
        for (int k = 0; k < 6; k++) got[k] = -1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            if (ardy4_s != 4'b0000) begin
                got[ng] = int'(gid4);
                ng++;
            end
            tick();
        end
        chk("rr_order0", 64'(got[0]), 64'(0));
        chk("rr_order1", 64'(got[1]), 64'(1));
        chk("rr_order2", 64'(got[2]), 64'(3));
        chk("rr_order3", 64'(got[3]), 64'(0));
        chk("rr_order4", 64'(got[4]), 64'(1));
        chk("rr_order5", 64'(got[5]), 64'(3));

        // backpressure in DATA for 5 cycles
        do_reset();
        arv4 = 4'b0010;
        tick();
        m_ardy4 = 1'b1;
        tick();
        arv4 = 4'b0000; m_ardy4 = 1'b0; m_rv4 = 1'b1; rrdy4 = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold[%0d]", c), {m_rrdy4, busy4, rv4_s}, {1'b0, 1'b1, 4'b0010});
            tick();
        end
        rrdy4 = 4'b0010;
        @(negedge clk);
        chk("bp_release", {m_rrdy4, busy4, rv4_s}, {1'b1, 1'b1, 4'b0010});
        tick();
        m_rv4 = 1'b0; rrdy4 = 4'b0000;
        @(negedge clk);
        chk("bp_done_idle", {busy4, m_rrdy4, rv4_s}, {1'b0, 1'b0, 4'b0000});

        // mid-transaction reset: master 0 completes first so last_id would favour 3
        do_reset();
        arv4 = 4'b0001;
        tick();
        m_ardy4 = 1'b1;
        tick();
        arv4 = 4'b0000; m_ardy4 = 1'b0; m_rv4 = 1'b1; rrdy4 = 4'b0001;
        tick();
        m_rv4 = 1'b0; rrdy4 = 4'b0000; arv4 = 4'b0100;
        tick();
        m_ardy4 = 1'b1;
        tick();
        arv4 = 4'b0000; m_ardy4 = 1'b0;
        @(negedge clk);
        chk("mr_in_data", {busy4, gid4}, {1'b1, 2'd2});
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("mr_idle_after", {busy4, m_arv4, m_rrdy4, rv4_s}, {1'b0, 1'b0, 1'b0, 4'b0000});
        arv4 = 4'b1001;
        tick();
        @(negedge clk);
        chk("mr_first_grant", {m_arv4, gid4, m_araddr4}, {1'b1, 2'd0, A0});

        // N = 1 back-to-back reads
        do_reset();
        arv1 = 1'b1; m_ardy1 = 1'b1; m_rv1 = 1'b1; rrdy1 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            logic [35:0] e1;
            case (c % 3)
                0:       e1 = {1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
                1:       e1 = {1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0ABC};
                default: e1 = {1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
            endcase
            @(negedge clk);
            chk($sformatf("n1_cyc[%0d]", c), {m_arv1, m_rrdy1, busy1, gid1, m_araddr1}, e1);
            chk($sformatf("n1_route[%0d]", c), {ardy1_s, rv1_s},
                {(c % 3) == 1, (c % 3) == 2});
            tick();
        end
        chk("n1_rdata_fwd", {s_rdata1, s_rresp1}, {32'h1234_5678, 2'b01});

        // randomized traffic against a transaction-level model
        do_reset();
        owner = -1; in_data = 1'b0; last = 3;
        for (int i = 0; i < 4; i++) begin
            mreq[i] = 1'b0; mwait[i] = 1'b0; maddr[i] = 32'h0;
        end
        for (int c = 0; c < 1500; c++) begin
            logic        e_arv, e_rrdy, e_busy;
            logic [31:0] e_addr;
            logic [3:0]  e_ardy, e_rv;
            for (int i = 0; i < 4; i++) begin
                if (!mreq[i] && !mwait[i] && $urandom_range(0, 2) == 0) begin
                    mreq[i]  = 1'b1;
                    maddr[i] = $urandom;
                end
                arv4[i] = mreq[i];
                araddr4[i*AW +: AW] = maddr[i];
            end
            m_ardy4  = 1'($urandom_range(0, 1));
            m_rv4    = in_data && ($urandom_range(0, 1) == 1);
            rrdy4    = 4'($urandom);
            m_rdata4 = $urandom;
            m_rresp4 = 2'($urandom);
            @(negedge clk);
            e_arv = 1'b0; e_addr = '0; e_ardy = '0; e_rv = '0; e_rrdy = 1'b0;
            e_busy = (owner >= 0);
            if (owner >= 0 && !in_data) begin
                e_arv         = mreq[owner];
                e_addr        = maddr[owner];
                e_ardy[owner] = m_ardy4;
            end
            if (owner >= 0 && in_data) begin
                e_rv[owner] = m_rv4;
                e_rrdy      = rrdy4[owner];
            end
            chk($sformatf("rand[%0d]", c),
                {m_arv4, m_araddr4, ardy4_s, rv4_s, m_rrdy4, busy4},
                {e_arv, e_addr, e_ardy, e_rv, e_rrdy, e_busy});
            if (owner >= 0)
                chk($sformatf("rand_gid[%0d]", c), 64'(gid4), 64'(owner));
            chk($sformatf("rand_rdata[%0d]", c), {s_rdata4, s_rresp4}, {m_rdata4, m_rresp4});
            if (owner < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (owner < 0 && mreq[(last + k) % 4]) owner = (last + k) % 4;
                end
                in_data = 1'b0;
            end else if (!in_data) begin
                if (mreq[owner] && m_ardy4) begin
                    in_data      = 1'b1;
                    mreq[owner]  = 1'b0;
                    mwait[owner] = 1'b1;
                end
            end else if (m_rv4 && rrdy4[owner]) begin
                last         = owner;
                mwait[owner] = 1'b0;
                owner        = -1;
                in_data      = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
